// File: rtl/dmem_arbiter.sv
// Data-RAM arbiter: the CPU load/store port has priority over an external req/gnt port.
// A starvation counter steals one beat for the external side by stalling the CPU for a cycle.
module dmem_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic              dbg_state
);

  typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} state_t;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                ext_rvalid_q;
  logic [DATA_W-1:0]   ext_rdata_q;

  logic cpu_acc;
  logic force_beat;
  logic ext_own;
  logic read_beat;

  // Handshake: an ext beat transfers in any cycle where ext_req & ext_gnt; the requester
  // holds addr/we/wdata stable until then, and read data follows one cycle later with ext_rvalid.
  always_comb begin
    cpu_acc    = cpu_we | cpu_re;
    force_beat = (state_q == FORCE) && ext_req;
    ext_own    = force_beat || (!cpu_acc && ext_req);

    ext_gnt    = rst & ext_own;
    cpu_stall  = rst & force_beat;
    mem_addr   = ext_own ? ext_addr  : cpu_addr;
    mem_data   = ext_own ? ext_wdata : cpu_wdata;
    mem_wren   = rst & (ext_own ? ext_we : cpu_we);
    cpu_rdata  = mem_q;
    read_beat  = ext_gnt & ~ext_we;
  end

  // Only a CPU-won NORMAL cycle keeps the count; every other case restarts it from zero.
  always_comb begin
    state_d    = NORMAL;
    wait_cnt_d = '0;
    if (state_q == NORMAL && cpu_acc) begin
      wait_cnt_d = wait_cnt_q;
      if (ext_req) begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = FORCE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= NORMAL;
      wait_cnt_q   <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      ext_rvalid_q <= read_beat;
      if (read_beat) begin
        ext_rdata_q <= mem_q;
      end
    end
  end

  assign ext_rvalid = ext_rvalid_q;
  assign ext_rdata  = ext_rdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter with a falling-edge RAM and an
// ownership/starvation reference model kept at transaction level.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] cpu_addr, ext_addr, mem_addr;
  logic [31:0] cpu_wdata, ext_wdata, cpu_rdata, ext_rdata, mem_data, mem_q;
  logic        cpu_we, cpu_re, cpu_stall, ext_req, ext_we, ext_gnt, ext_rvalid, mem_wren;
  logic        dbg_state;

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(MAX_WAIT), .WAIT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .dbg_state(dbg_state)
  );

  // clock / RAM environment
  always #5 clk = ~clk;

  logic [31:0] ram [4096];
  always @(negedge clk) begin
    mem_q <= ram[mem_addr];
    if (mem_wren) ram[mem_addr] <= mem_data;
  end

  // reference model state
  logic [31:0] exp_mem [4096];
  int          losses;
  bit          fp;
  bit          exp_rvalid;
  logic [31:0] exp_rdata;
  bit          m_ext_granted;
  logic        last_gnt, last_stall;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1 with inputs already driven; returns at the next posedge+1.
  task automatic do_cycle(input bit rst_v, input bit mid_rst);
    int          own;  // 0 reset, 1 cpu, 2 ext, 3 idle
    bit          acc, e_stall, cpu_rd, n_rvalid;
    logic [31:0] exp_rd, n_rdata;
    acc     = cpu_we | cpu_re;
    rst     = rst_v;
    e_stall = 1'b0;
    if (!rst_v) begin
      own = 0; losses = 0; fp = 1'b0;
    end else if (fp) begin
      own     = ext_req ? 2 : (acc ? 1 : 3);
      e_stall = ext_req;
      losses  = 0; fp = 1'b0;
    end else if (acc) begin
      own = 1;
      if (ext_req) begin
        losses++;
        if (losses >= MAX_WAIT) fp = 1'b1;
      end
    end else begin
      own = ext_req ? 2 : 3;
      losses = 0;
    end
    #2;
    last_gnt   = ext_gnt;
    last_stall = cpu_stall;
    chk("ext_gnt", ext_gnt, own == 2);
    chk("cpu_stall", cpu_stall, e_stall);
    chk("mem_wren", mem_wren, (own == 1 && cpu_we) || (own == 2 && ext_we));
    if (own == 1 || own == 3) chk("mem_addr_cpu", mem_addr, cpu_addr);
    if (own == 1) chk("mem_data_cpu", mem_data, cpu_wdata);
    if (own == 2) begin
      chk("mem_addr_ext", mem_addr, ext_addr);
      chk("mem_data_ext", mem_data, ext_wdata);
    end
    cpu_rd = (own == 1) && cpu_re;
    exp_rd = exp_mem[cpu_addr];
    n_rvalid = 1'b0;
    n_rdata  = rst_v ? exp_rdata : 32'h0;
    if (own == 2 && !ext_we) begin
      n_rvalid = 1'b1;
      n_rdata  = exp_mem[ext_addr];
    end
    if (own == 1 && cpu_we) exp_mem[cpu_addr] = cpu_wdata;
    if (own == 2 && ext_we) exp_mem[ext_addr] = ext_wdata;
    m_ext_granted = (own == 2);
    @(negedge clk); #1;
    if (cpu_rd) chk("cpu_rdata", cpu_rdata, exp_rd);
    if (mid_rst) begin
      rst = 1'b0;
      n_rvalid = 1'b0; n_rdata = 32'h0; losses = 0; fp = 1'b0;
      chk("rvalid_mid_rst", ext_rvalid, 1'b0);
    end
    @(posedge clk); #1;
    exp_rvalid = n_rvalid;
    exp_rdata  = n_rdata;
    chk("ext_rvalid", ext_rvalid, exp_rvalid);
    chk("ext_rdata", ext_rdata, exp_rdata);
  endtask

  task automatic set_cpu(input bit we, input bit re, input logic [11:0] a, input logic [31:0] d);
    cpu_we = we; cpu_re = re; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_ext(input bit req, input bit we, input logic [11:0] a, input logic [31:0] d);
    ext_req = req; ext_we = we; ext_addr = a; ext_wdata = d;
  endtask

  initial begin
    int r;
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 32'h0; exp_mem[i] = 32'h0;
    end
    losses = 0; fp = 1'b0; exp_rvalid = 1'b0; exp_rdata = 32'h0; m_ext_granted = 1'b0;
    set_cpu(1'b1, 1'b0, 12'h005, 32'hCAFE0000);
    set_ext(1'b1, 1'b1, 12'h006, 32'h12345678);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // reset held with traffic present: no grant, stall or write may escape
    do_cycle(1'b0, 1'b0);
    do_cycle(1'b0, 1'b0);
    set_cpu(1'b0, 1'b0, 12'h0, 32'h0);
    set_ext(1'b0, 1'b0, 12'h0, 32'h0);
    do_cycle(1'b1, 1'b0);
    chk("t1_ram_untouched", ram[12'h006], 32'h0);

    // CPU store then load
    set_cpu(1'b1, 1'b0, 12'h010, 32'hDEADBEEF);
    do_cycle(1'b1, 1'b0);
    set_cpu(1'b0, 1'b1, 12'h010, 32'h0);
    do_cycle(1'b1, 1'b0);
    chk("t2_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // ext read with CPU idle
    set_cpu(1'b0, 1'b0, 12'h0, 32'h0);
    set_ext(1'b1, 1'b0, 12'h010, 32'h0);
    do_cycle(1'b1, 1'b0);
    chk("t3_gnt", last_gnt, 1'b1);
    chk("t3_rvalid", ext_rvalid, 1'b1);
    chk("t3_rdata", ext_rdata, 32'hDEADBEEF);
    set_ext(1'b0, 1'b0, 12'h0, 32'h0);
    do_cycle(1'b1, 1'b0);
    chk("t3_rvalid_drop", ext_rvalid, 1'b0);

    // starvation: four CPU wins, then one forced ext beat
    set_cpu(1'b0, 1'b1, 12'h100, 32'h0);
    set_ext(1'b1, 1'b0, 12'h010, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      do_cycle(1'b1, 1'b0);
      chk($sformatf("t4_gnt_c%0d", i), last_gnt, i == 5);
      chk($sformatf("t4_stall_c%0d", i), last_stall, i == 5);
    end
    set_cpu(1'b0, 1'b0, 12'h0, 32'h0);
    set_ext(1'b0, 1'b0, 12'h0, 32'h0);
    do_cycle(1'b1, 1'b0);

    // simultaneous writes to one address: CPU first, ext next cycle
    set_cpu(1'b1, 1'b0, 12'h020, 32'h1111);
    set_ext(1'b1, 1'b1, 12'h020, 32'h2222);
    do_cycle(1'b1, 1'b0);
    chk("t5_gnt0", last_gnt, 1'b0);
    chk("t5_ram_cpu", ram[12'h020], 32'h1111);
    set_cpu(1'b0, 1'b0, 12'h0, 32'h0);
    do_cycle(1'b1, 1'b0);
    chk("t5_gnt1", last_gnt, 1'b1);
    chk("t5_ram_ext", ram[12'h020], 32'h2222);
    set_ext(1'b0, 1'b0, 12'h0, 32'h0);
    do_cycle(1'b1, 1'b0);

    // FORCE pending, request withdrawn
    set_cpu(1'b0, 1'b1, 12'h030, 32'h0);
    set_ext(1'b1, 1'b0, 12'h040, 32'h0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0);
    set_ext(1'b0, 1'b0, 12'h040, 32'h0);
    do_cycle(1'b1, 1'b0);
    chk("t6_withdraw_stall", last_stall, 1'b0);
    set_ext(1'b1, 1'b0, 12'h040, 32'h0);
    do_cycle(1'b1, 1'b0);
    chk("t6_count_cleared", last_stall, 1'b0);

    // FORCE pending, reset in that cycle
    set_cpu(1'b0, 1'b0, 12'h0, 32'h0);
    set_ext(1'b0, 1'b0, 12'h0, 32'h0);
    do_cycle(1'b1, 1'b0);
    set_cpu(1'b0, 1'b1, 12'h030, 32'h0);
    set_ext(1'b1, 1'b0, 12'h040, 32'h0);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0);
    do_cycle(1'b0, 1'b0);
    chk("t6_rst_stall", last_stall, 1'b0);
    do_cycle(1'b1, 1'b0);
    chk("t6_post_rst_stall", last_stall, 1'b0);

    // granted ext read dropped by reset before its data returns
    set_cpu(1'b0, 1'b0, 12'h0, 32'h0);
    set_ext(1'b1, 1'b0, 12'h010, 32'h0);
    do_cycle(1'b1, 1'b1);
    chk("t7_no_rvalid", ext_rvalid, 1'b0);
    set_ext(1'b0, 1'b0, 12'h0, 32'h0);
    do_cycle(1'b1, 1'b0);

    // randomized traffic; ext request held until the model grants it
    m_ext_granted = 1'b1;
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      set_cpu(r >= 7, (r >= 3 && r <= 6) || r == 9, 12'($urandom_range(0, 15)), $urandom);
      if (!ext_req || m_ext_granted)
        set_ext($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                12'($urandom_range(0, 15)), $urandom);
      do_cycle($urandom_range(0, 99) != 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
